akarin_fetch: RTL
=================

AKARIN_FETCH -- requirements
Module: akarin_fetch

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 Port clk  input  1  sole clock; all state updates on posedge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port instBus  memory_bus.master  -  instruction memory. Fields used:
- req, addr[31:0]: driven by this block.
- ready, rvalid, rdata[31:0]: sampled by this block.
- we: tied to 0.
REQ-006 Port redirect  input  1  flush and restart fetch.
REQ-007 Port redirect_pc  input  32  restart address, valid with redirect.
REQ-008 Port if_valid  output  1  if_pc/if_inst hold a fetched instruction.
REQ-009 Port if_ready  input  1  decode accepts the presented instruction; low means stall.
REQ-010 Port if_pc  output  32  address of the presented instruction.
REQ-011 Port if_inst  output  32  presented instruction word.
REQ-012 Port if_stop  output  1  fetch starved: buffer empty and no data arriving this cycle.

Function
REQ-013 FSM states:
- IDLE: one cycle after reset release, then REQ.
- REQ: req=1, addr=pc; on ready go to WAIT.
- WAIT: await rvalid.
REQ-014 In WAIT, on rvalid:
- go to REQ if the buffer will have a free slot next cycle;
- otherwise go to HOLD, which returns to REQ once a slot frees.
REQ-015 At most one outstanding request; req SHALL be 0 in IDLE, WAIT and HOLD.
REQ-016 addr and req SHALL remain stable from assertion until ready is sampled high.
REQ-017 On the ready handshake, pc <= pc + 4 (32-bit wrap, FFFF_FFFC -> 0000_0000); the issued address is retained for tagging.
REQ-018 On rvalid with no pending discard, {issued address, rdata} SHALL be written into a 2-entry FIFO.
REQ-019 FIFO output drives if_valid/if_pc/if_inst; pop occurs when if_valid && if_ready.
REQ-020 Simultaneous push and pop while full SHALL be legal.
REQ-021 Push while full without pop SHALL never occur (guaranteed by REQ-014).
REQ-022 Redirect has priority over all other events in the same cycle:
- FIFO cleared; if_valid=0 next cycle;
- pc <= {redirect_pc[31:2], 2'b00};
- FSM -> REQ.
REQ-023 If redirect occurs while a request is accepted but not yet returned (WAIT, or REQ with ready high), a discard flag SHALL be set. The next rvalid is then dropped and clears the flag. No new req is issued until the flag clears.
REQ-024 A redirect in REQ with ready low SHALL update addr in the same cycle with no discard.
REQ-025 if_stop = !if_valid && !(rvalid && !discard); combinational.
REQ-026 Latency: addr handshake -> rvalid -> if_valid one cycle after rvalid (registered FIFO).
REQ-027 Sustained throughput with single-cycle ready and rvalid: one instruction per 2 cycles.

Reset
REQ-028 While rst=0, the block SHALL hold:
- pc=RESET_PC, FSM=IDLE;
- FIFO empty, discard=0;
- req=0, addr=RESET_PC;
- if_valid=0, if_pc=0, if_inst=INST_NOP;
- if_stop=1.
REQ-029 Reset assertion mid-transaction SHALL abandon the outstanding request; any later rvalid with discard=0 and state IDLE SHALL be ignored.

Structure
REQ-030 Package akarin_pkg (via akarin.svh) SHALL hold:
- XLEN=32;
- INST_NOP=32'h0000_0013;
- typedef fetch_entry_t {pc, inst};
- typedef fetch_state_t {IDLE, REQ, WAIT, HOLD}.
REQ-031 The FIFO SHALL be sub-module akarin_fetch_fifo: 2 entries of fetch_entry_t, push/pop/flush, full/empty outputs.

Verification
REQ-032 Reset release, ready=1, rvalid one cycle after handshake, if_ready=1 -> addr sequence 0,4,8; if_pc 0,4,8 matching rdata.
REQ-033 if_ready=0 for 10 cycles -> two entries buffered, FSM in HOLD, req=0; if_ready=1 -> pops in order, fetch resumes at pc 8.
REQ-034 Redirect to 32'h0000_0103 in WAIT -> stale rvalid dropped, next addr=0000_0100, first if_pc=0000_0100.
REQ-035 ready held low 5 cycles -> addr and req stable throughout; if_stop=1 throughout.
REQ-036 Redirect to FFFF_FFFC -> fetches FFFF_FFFC then 0000_0000.
REQ-037 rst asserted in WAIT -> all outputs at reset values immediately; a later rvalid produces no if_valid.

Source files
------------

// File: rtl/akarin_pkg.sv
// Shared types and constants for the akarin instruction fetch path.
package akarin_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t IDLE = 2'd0;
  localparam fetch_state_t REQ  = 2'd1;
  localparam fetch_state_t WAIT = 2'd2;
  localparam fetch_state_t HOLD = 2'd3;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/akarin_fetch_fifo.sv
// Two-entry fetch buffer; head is registered, visible the cycle after push.
// Push while full is accepted only alongside a pop; flush beats push and pop.
module akarin_fetch_fifo
  import akarin_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_dat,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head_dat,
  output logic         full,
  output logic         empty
);

  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // An empty buffer presents a NOP at pc 0 so decode never sees stale data.
  assign head_dat = empty ? '{pc: '0, inst: INST_NOP} : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = !wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = !rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= '{pc: '0, inst: INST_NOP};
      mem_q[1] <= '{pc: '0, inst: INST_NOP};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/akarin_fetch.sv
// Instruction fetch: one outstanding bus request, 2-entry buffer to decode.
// rvalid -> if_valid is one cycle; decode stall parks the FSM in HOLD when full.
module akarin_fetch
  import akarin_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)
(
  input  logic            clk,
  input  logic            rst,
  output logic            inst_bus_req,
  output logic [XLEN-1:0] inst_bus_addr,
  output logic            inst_bus_we,
  input  logic            inst_bus_ready,
  input  logic            inst_bus_rvalid,
  input  logic [XLEN-1:0] inst_bus_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_inst,
  output logic            if_stop
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] issued_q, issued_d;
  logic            discard_q, discard_d;

  logic            hs, accept, pop, in_flight, full_after_push;
  logic            fifo_full, fifo_empty;
  fetch_entry_t    head, push_dat;

  assign inst_bus_req  = (state_q == REQ) && !discard_q;
  assign inst_bus_addr = pc_q;
  assign inst_bus_we   = 1'b0;

  assign hs     = inst_bus_req && inst_bus_ready;
  assign accept = inst_bus_rvalid && !discard_q && (state_q == WAIT);
  assign pop    = if_valid && if_ready;

  // A redirect leaves an orphan response behind if a request is on the bus.
  assign in_flight = ((state_q == WAIT) && !inst_bus_rvalid) || hs ||
                     (discard_q && !inst_bus_rvalid);

  assign full_after_push = fifo_full || (if_valid && !pop);
  assign push_dat        = '{pc: issued_q, inst: inst_bus_rdata};

  assign if_valid = !fifo_empty;
  assign if_pc    = head.pc;
  assign if_inst  = head.inst;
  assign if_stop  = !if_valid && !accept;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    issued_d  = issued_q;
    discard_d = discard_q;
    if (inst_bus_rvalid && discard_q) begin
      discard_d = 1'b0;
    end
    if (hs) begin
      pc_d     = pc_q + 32'd4;
      issued_d = pc_q;
    end
    case (state_q)
      IDLE:    state_d = REQ;
      REQ:     if (hs) state_d = WAIT;
      WAIT:    if (accept) state_d = full_after_push ? HOLD : REQ;
      HOLD:    if (!fifo_full || pop) state_d = REQ;
      default: state_d = IDLE;
    endcase
    if (redirect) begin
      state_d   = REQ;
      pc_d      = align_pc(redirect_pc);
      discard_d = in_flight;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      issued_q  <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      issued_q  <= issued_d;
      discard_q <= discard_d;
    end
  end

  akarin_fetch_fifo u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept && !redirect),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (redirect),
    .head_dat (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule
